// File: rtl/id_stage_pkg.sv
// Shared definitions for the instruction-decode stage: widths, opcodes,
// control bundle layout and ALU operation encodings.
package id_stage_pkg;

  localparam int NB_PC          = 32;
  localparam int NB_INSTRUCTION = 32;
  localparam int NB_DATA        = 32;
  localparam int NB_REG_ADDR    = 5;
  localparam int NB_CTRL        = 10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_REG_DST    = 5;
  localparam int CTRL_LINK       = 6;
  localparam int CTRL_ALU_OP_LSB = 7;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_RTYPE = 3'd2;
  localparam logic [2:0] ALU_SLT   = 3'd3;
  localparam logic [2:0] ALU_AND   = 3'd4;
  localparam logic [2:0] ALU_OR    = 3'd5;
  localparam logic [2:0] ALU_LUI   = 3'd6;

  // Packed so that field positions match the CTRL_* indices above.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       link;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
  } ctrl_t;

  typedef struct packed {
    logic is_beq;
    logic is_bne;
    logic is_j;
    logic is_jal;
    logic is_jr;
    logic reads_rt;
    logic zero_ext;
  } decode_t;

endpackage

// File: rtl/id_stage_register_file.sv
// 32-entry register file: two combinational read ports with write-through
// bypass, one synchronous write port, r0 hardwired to zero.
module register_file
  import id_stage_pkg::*;
#(
  parameter int DATA_W = NB_DATA,
  parameter int ADDR_W = NB_REG_ADDR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr_a,
  input  logic [ADDR_W-1:0] read_addr_b,
  output logic [DATA_W-1:0] read_data_a,
  output logic [DATA_W-1:0] read_data_b
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (write_en && (write_addr != '0)) begin
      regs[write_addr] <= write_data;
    end
  end

  // A read of the register being written this cycle sees the new value.
  always_comb begin
    read_data_a = '0;
    if (read_addr_a != '0) begin
      if (write_en && (write_addr == read_addr_a)) read_data_a = write_data;
      else                                         read_data_a = regs[read_addr_a];
    end
  end

  always_comb begin
    read_data_b = '0;
    if (read_addr_b != '0) begin
      if (write_en && (write_addr == read_addr_b)) read_data_b = write_data;
      else                                         read_data_b = regs[read_addr_b];
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: control decode, immediate extension, in-ID
// branch/jump resolution, hazard stalling and the registered ID/EX bundle.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int NB_PC          = id_stage_pkg::NB_PC,
  parameter int NB_INSTRUCTION = id_stage_pkg::NB_INSTRUCTION,
  parameter int NB_DATA        = id_stage_pkg::NB_DATA,
  parameter int NB_REG_ADDR    = id_stage_pkg::NB_REG_ADDR,
  parameter int NB_CTRL        = id_stage_pkg::NB_CTRL
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_ID_enable,
  input  logic [NB_INSTRUCTION-1:0] i_ID_instruction,
  input  logic [NB_PC-1:0]          i_ID_pc_plus4,
  input  logic                      i_ID_wb_write,
  input  logic [NB_REG_ADDR-1:0]    i_ID_wb_addr,
  input  logic [NB_DATA-1:0]        i_ID_wb_data,
  input  logic                      i_ID_exmem_reg_write,
  input  logic [NB_REG_ADDR-1:0]    i_ID_exmem_dest,
  output logic                      o_ID_branch,
  output logic                      o_ID_jump,
  output logic [NB_PC-1:0]          o_ID_branch_addr,
  output logic [NB_PC-1:0]          o_ID_jump_addr,
  output logic                      o_ID_stall,
  output logic [NB_DATA-1:0]        o_ID_rs_data,
  output logic [NB_DATA-1:0]        o_ID_rt_data,
  output logic [NB_DATA-1:0]        o_ID_imm_ext,
  output logic [NB_REG_ADDR-1:0]    o_ID_rs,
  output logic [NB_REG_ADDR-1:0]    o_ID_rt,
  output logic [NB_REG_ADDR-1:0]    o_ID_rd,
  output logic [NB_PC-1:0]          o_ID_pc_plus4,
  output logic [NB_CTRL-1:0]        o_ID_ctrl
);

  logic [5:0]             opcode;
  logic [5:0]             funct;
  logic [NB_REG_ADDR-1:0] rs;
  logic [NB_REG_ADDR-1:0] rt;
  logic [NB_REG_ADDR-1:0] rd;
  logic [15:0]            imm16;

  assign opcode = i_ID_instruction[31:26];
  assign funct  = i_ID_instruction[5:0];
  assign rs     = i_ID_instruction[25:21];
  assign rt     = i_ID_instruction[20:16];
  assign rd     = i_ID_instruction[15:11];
  assign imm16  = i_ID_instruction[15:0];

  logic [NB_DATA-1:0] rs_val;
  logic [NB_DATA-1:0] rt_val;

  register_file #(
    .DATA_W (NB_DATA),
    .ADDR_W (NB_REG_ADDR)
  ) u_register_file (
    .clock       (i_clock),
    .reset       (i_reset),
    .write_en    (i_ID_wb_write),
    .write_addr  (i_ID_wb_addr),
    .write_data  (i_ID_wb_data),
    .read_addr_a (rs),
    .read_addr_b (rt),
    .read_data_a (rs_val),
    .read_data_b (rt_val)
  );

  ctrl_t   ctrl;
  decode_t dec;

  always_comb begin
    ctrl = '0;
    dec  = '0;
    unique case (opcode)
      OP_RTYPE: begin
        if (funct == FUNCT_JR) begin
          dec.is_jr = 1'b1;
        end else if (i_ID_instruction != '0) begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
          ctrl.alu_op    = ALU_RTYPE;
          dec.reads_rt   = 1'b1;
        end
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_SLTI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_SLT;
      end
      OP_ANDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_AND;
        dec.zero_ext   = 1'b1;
      end
      OP_ORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OR;
        dec.zero_ext   = 1'b1;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_LUI;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        dec.reads_rt   = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op  = ALU_SUB;
        dec.is_beq   = 1'b1;
        dec.reads_rt = 1'b1;
      end
      OP_BNE: begin
        ctrl.alu_op  = ALU_SUB;
        dec.is_bne   = 1'b1;
        dec.reads_rt = 1'b1;
      end
      OP_J: begin
        dec.is_j = 1'b1;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.link      = 1'b1;
        dec.is_jal     = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

  logic [NB_DATA-1:0]     imm_ext;
  logic [NB_REG_ADDR-1:0] dest_rd;

  assign imm_ext = dec.zero_ext ? {{(NB_DATA-16){1'b0}}, imm16}
                                : {{(NB_DATA-16){imm16[15]}}, imm16};
  assign dest_rd = dec.is_jal ? {NB_REG_ADDR{1'b1}} : rd;

  // ID/EX pipeline register contents.
  ctrl_t                  ctrl_q;
  logic [NB_DATA-1:0]     rs_data_q;
  logic [NB_DATA-1:0]     rt_data_q;
  logic [NB_DATA-1:0]     imm_q;
  logic [NB_REG_ADDR-1:0] rs_q;
  logic [NB_REG_ADDR-1:0] rt_q;
  logic [NB_REG_ADDR-1:0] rd_q;
  logic [NB_PC-1:0]       pc_plus4_q;

  // Register the older instruction will write (rd for R-type and JAL, else rt).
  logic [NB_REG_ADDR-1:0] idex_dest;
  logic                   load_use;
  logic                   rs_hit;
  logic                   rt_hit;
  logic                   branch_hazard;
  logic                   stall_raw;
  logic                   taken;
  logic                   is_branch_src;

  assign idex_dest = (ctrl_q.reg_dst || ctrl_q.link) ? rd_q : rt_q;

  assign load_use = ctrl_q.mem_read && (rt_q != '0) &&
                    ((rt_q == rs) || (dec.reads_rt && (rt_q == rt)));

  assign rs_hit = (rs != '0) &&
                  ((ctrl_q.reg_write && (idex_dest == rs)) ||
                   (i_ID_exmem_reg_write && (i_ID_exmem_dest == rs)));
  assign rt_hit = (rt != '0) &&
                  ((ctrl_q.reg_write && (idex_dest == rt)) ||
                   (i_ID_exmem_reg_write && (i_ID_exmem_dest == rt)));

  assign is_branch_src = dec.is_beq || dec.is_bne;
  assign branch_hazard = (is_branch_src || dec.is_jr) &&
                         (rs_hit || (is_branch_src && rt_hit));
  assign stall_raw     = load_use || branch_hazard;

  assign taken = (dec.is_beq && (rs_val == rt_val)) ||
                 (dec.is_bne && (rs_val != rt_val));

  assign o_ID_stall       = i_ID_enable && stall_raw;
  assign o_ID_branch      = i_ID_enable && !stall_raw && taken;
  assign o_ID_jump        = i_ID_enable && !stall_raw &&
                            (dec.is_j || dec.is_jal || dec.is_jr);
  assign o_ID_branch_addr = i_ID_pc_plus4 + {imm_ext[NB_PC-3:0], 2'b00};
  assign o_ID_jump_addr   = dec.is_jr ? rs_val[NB_PC-1:0]
                                      : {i_ID_pc_plus4[NB_PC-1:NB_PC-4],
                                         i_ID_instruction[25:0], 2'b00};

  // Freeze holds the bundle; a stall inserts a bubble instead of the decode.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      ctrl_q     <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      pc_plus4_q <= '0;
    end else if (i_ID_enable) begin
      if (stall_raw) begin
        ctrl_q     <= '0;
        rs_data_q  <= '0;
        rt_data_q  <= '0;
        imm_q      <= '0;
        rs_q       <= '0;
        rt_q       <= '0;
        rd_q       <= '0;
        pc_plus4_q <= '0;
      end else begin
        ctrl_q     <= ctrl;
        rs_data_q  <= rs_val;
        rt_data_q  <= rt_val;
        imm_q      <= imm_ext;
        rs_q       <= rs;
        rt_q       <= rt;
        rd_q       <= dest_rd;
        pc_plus4_q <= i_ID_pc_plus4;
      end
    end
  end

  assign o_ID_ctrl     = ctrl_q;
  assign o_ID_rs_data  = rs_data_q;
  assign o_ID_rt_data  = rt_data_q;
  assign o_ID_imm_ext  = imm_q;
  assign o_ID_rs       = rs_q;
  assign o_ID_rt       = rt_q;
  assign o_ID_rd       = rd_q;
  assign o_ID_pc_plus4 = pc_plus4_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a decode vector table plus hand-written
// sequences for stalls, freeze, write-through bypass and async reset.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic        wb_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        exmem_reg_write;
  logic [4:0]  exmem_dest;
  logic        branch;
  logic        jump;
  logic [31:0] branch_addr;
  logic [31:0] jump_addr;
  logic        stall;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] pc_plus4_q;
  logic [9:0]  ctrl;

  id_stage dut (
    .i_clock              (clk),
    .i_reset              (rst),
    .i_ID_enable          (enable),
    .i_ID_instruction     (instr),
    .i_ID_pc_plus4        (pc4),
    .i_ID_wb_write        (wb_write),
    .i_ID_wb_addr         (wb_addr),
    .i_ID_wb_data         (wb_data),
    .i_ID_exmem_reg_write (exmem_reg_write),
    .i_ID_exmem_dest      (exmem_dest),
    .o_ID_branch          (branch),
    .o_ID_jump            (jump),
    .o_ID_branch_addr     (branch_addr),
    .o_ID_jump_addr       (jump_addr),
    .o_ID_stall           (stall),
    .o_ID_rs_data         (rs_data),
    .o_ID_rt_data         (rt_data),
    .o_ID_imm_ext         (imm_ext),
    .o_ID_rs              (rs),
    .o_ID_rt              (rt),
    .o_ID_rd              (rd),
    .o_ID_pc_plus4        (pc_plus4_q),
    .o_ID_ctrl            (ctrl)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [9:0]  ctrl;
    logic [31:0] imm;
    logic        br;
    logic        jp;
    logic [31:0] baddr;
    logic [31:0] jaddr;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] fn);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tg);
    return {op, tg};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic en);
    instr  = i;
    pc4    = p;
    enable = en;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    drive(32'h0, 32'h0, 1'b0);
    wb_write = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    step();
    wb_write = 1'b0;
  endtask

  initial begin
    // Order: instr, pc4, ctrl, imm, branch, jump, baddr, jaddr, rs_data, rt_data, rd
    vecs[0]  = '{enc_r(1, 2, 8, 6'h20),           32'h1000,      10'h121, 32'h0000_4020, 1'b0, 1'b0, 32'h0,     32'h0,         32'd5,  32'd5, 5'd8};
    vecs[1]  = '{enc_i(6'h0C, 3, 9, 16'hFFF0),    32'h1004,      10'h211, 32'h0000_FFF0, 1'b0, 1'b0, 32'h0,     32'h0,         32'd7,  32'd0, 5'd31};
    vecs[2]  = '{enc_i(6'h0D, 4, 10, 16'h8001),   32'h1008,      10'h291, 32'h0000_8001, 1'b0, 1'b0, 32'h0,     32'h0,         32'h10, 32'd0, 5'd16};
    vecs[3]  = '{enc_i(6'h0A, 1, 11, 16'h8000),   32'h100C,      10'h191, 32'hFFFF_8000, 1'b0, 1'b0, 32'h0,     32'h0,         32'd5,  32'd0, 5'd16};
    vecs[4]  = '{enc_i(6'h0F, 0, 12, 16'h1234),   32'h1010,      10'h311, 32'h0000_1234, 1'b0, 1'b0, 32'h0,     32'h0,         32'd0,  32'd0, 5'd2};
    vecs[5]  = '{enc_i(6'h2B, 3, 1, 16'h0004),    32'h1014,      10'h014, 32'h0000_0004, 1'b0, 1'b0, 32'h0,     32'h0,         32'd7,  32'd5, 5'd0};
    vecs[6]  = '{enc_i(6'h04, 1, 2, 16'h0003),    32'h0000_0100, 10'h080, 32'h0000_0003, 1'b1, 1'b0, 32'h10C,   32'h0,         32'd5,  32'd5, 5'd0};
    vecs[7]  = '{enc_i(6'h05, 1, 2, 16'h0003),    32'h0000_0100, 10'h080, 32'h0000_0003, 1'b0, 1'b0, 32'h0,     32'h0,         32'd5,  32'd5, 5'd0};
    vecs[8]  = '{enc_i(6'h05, 1, 3, 16'hFFFF),    32'h0000_0200, 10'h080, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h1FC,   32'h0,         32'd5,  32'd7, 5'd31};
    vecs[9]  = '{enc_j(6'h02, 26'h40),            32'h1000_0004, 10'h000, 32'h0000_0040, 1'b0, 1'b1, 32'h0,     32'h1000_0100, 32'd0,  32'd0, 5'd0};
    vecs[10] = '{enc_j(6'h03, 26'h40),            32'h1000_0004, 10'h041, 32'h0000_0040, 1'b0, 1'b1, 32'h0,     32'h1000_0100, 32'd0,  32'd0, 5'd31};
    vecs[11] = '{enc_r(4, 0, 0, 6'h08),           32'h2000,      10'h000, 32'h0000_0008, 1'b0, 1'b1, 32'h0,     32'h10,        32'h10, 32'd0, 5'd0};
    vecs[12] = '{32'h0,                           32'h2004,      10'h000, 32'h0000_0000, 1'b0, 1'b0, 32'h0,     32'h0,         32'd0,  32'd0, 5'd0};
    vecs[13] = '{enc_i(6'h3F, 1, 2, 16'h1234),    32'h2008,      10'h000, 32'h0000_1234, 1'b0, 1'b0, 32'h0,     32'h0,         32'd5,  32'd5, 5'd2};
    vecs[14] = '{enc_i(6'h23, 1, 13, 16'h0000),   32'h200C,      10'h01B, 32'h0000_0000, 1'b0, 1'b0, 32'h0,     32'h0,         32'd5,  32'd0, 5'd0};

    rst = 1'b1;
    enable = 1'b0;
    instr = '0;
    pc4 = '0;
    wb_write = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    exmem_reg_write = 1'b0;
    exmem_dest = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {22'd0, ctrl}, 32'h0);
    check("reset_rs_data", rs_data, 32'h0);
    check("reset_pc_plus4", pc_plus4_q, 32'h0);
    check("reset_stall", {31'd0, stall}, 32'h0);
    rst = 1'b0;
    step();

    wb(5'd1, 32'd5);
    wb(5'd2, 32'd5);
    wb(5'd3, 32'd7);
    wb(5'd4, 32'h10);

    // Vector table, scoreboarded through exp_q for the registered control bundle
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].instr, vecs[i].pc4, 1'b1);
      #1;
      check($sformatf("v%0d_branch", i), {31'd0, branch}, {31'd0, vecs[i].br});
      check($sformatf("v%0d_jump", i), {31'd0, jump}, {31'd0, vecs[i].jp});
      check($sformatf("v%0d_stall", i), {31'd0, stall}, 32'h0);
      if (vecs[i].br) check($sformatf("v%0d_branch_addr", i), branch_addr, vecs[i].baddr);
      if (vecs[i].jp) check($sformatf("v%0d_jump_addr", i), jump_addr, vecs[i].jaddr);
      exp_q.push_back(vecs[i].ctrl);
      step();
      check($sformatf("v%0d_ctrl", i), {22'd0, ctrl}, {22'd0, exp_q.pop_front()});
      check($sformatf("v%0d_imm", i), imm_ext, vecs[i].imm);
      check($sformatf("v%0d_rs_data", i), rs_data, vecs[i].rs_d);
      check($sformatf("v%0d_rt_data", i), rt_data, vecs[i].rt_d);
      check($sformatf("v%0d_rd", i), {27'd0, rd}, {27'd0, vecs[i].rd});
      check($sformatf("v%0d_pc_plus4", i), pc_plus4_q, vecs[i].pc4);
    end

    // Load-use: LW r2 then ADD r3,r2,r4; freeze first (hold beats stall)
    drive(enc_i(6'h23, 1, 2, 16'h0), 32'h3000, 1'b1);
    step();
    check("lw_ctrl", {22'd0, ctrl}, 32'h01B);
    drive(enc_r(2, 4, 3, 6'h20), 32'h3004, 1'b0);
    #1;
    check("hold_stall_masked", {31'd0, stall}, 32'h0);
    step();
    check("hold_ctrl_kept", {22'd0, ctrl}, 32'h01B);
    enable = 1'b1;
    #1;
    check("load_use_stall", {31'd0, stall}, 32'h1);
    step();
    check("load_use_bubble_ctrl", {22'd0, ctrl}, 32'h0);
    check("load_use_bubble_rs_data", rs_data, 32'h0);
    #1;
    check("load_use_released", {31'd0, stall}, 32'h0);
    step();
    check("add_issue_ctrl", {22'd0, ctrl}, 32'h121);
    check("add_issue_rs_data", rs_data, 32'd5);
    check("add_issue_rt_data", rt_data, 32'h10);
    check("add_issue_rd", {27'd0, rd}, 32'd3);
    check("add_issue_rs", {27'd0, rs}, 32'd2);
    check("add_issue_rt", {27'd0, rt}, 32'd4);

    // BEQ r7,r0 against an EX/MEM writer of r7
    drive(enc_i(6'h04, 7, 0, 16'h0001), 32'h300, 1'b1);
    exmem_reg_write = 1'b1;
    exmem_dest = 5'd7;
    #1;
    check("exmem_haz_stall", {31'd0, stall}, 32'h1);
    check("exmem_haz_branch", {31'd0, branch}, 32'h0);
    step();
    check("exmem_haz_bubble", {22'd0, ctrl}, 32'h0);
    exmem_reg_write = 1'b0;
    #1;
    check("exmem_clear_stall", {31'd0, stall}, 32'h0);
    check("exmem_clear_branch", {31'd0, branch}, 32'h1);
    check("exmem_clear_addr", branch_addr, 32'h304);
    step();

    // BEQ r14,r0 right behind ADDI r14 sitting in ID/EX
    drive(enc_i(6'h08, 0, 14, 16'h0001), 32'h400, 1'b1);
    step();
    check("addi_ctrl", {22'd0, ctrl}, 32'h011);
    drive(enc_i(6'h04, 14, 0, 16'h0002), 32'h400, 1'b1);
    #1;
    check("idex_haz_stall", {31'd0, stall}, 32'h1);
    check("idex_haz_branch", {31'd0, branch}, 32'h0);
    step();
    check("idex_haz_bubble", {22'd0, ctrl}, 32'h0);
    #1;
    check("idex_clear_branch", {31'd0, branch}, 32'h1);
    check("idex_clear_addr", branch_addr, 32'h408);
    step();

    // Freeze masks taken branch and jump
    drive(enc_i(6'h04, 1, 2, 16'h0003), 32'h500, 1'b0);
    #1;
    check("frozen_branch", {31'd0, branch}, 32'h0);
    step();
    check("frozen_ctrl_hold", {22'd0, ctrl}, 32'h080);
    drive(enc_j(6'h02, 26'h40), 32'h504, 1'b0);
    #1;
    check("frozen_jump", {31'd0, jump}, 32'h0);
    step();

    // Write-through: WB r5=0xAA while decoding ADDI r6,r5,-1
    drive(enc_i(6'h08, 5, 6, 16'hFFFF), 32'h600, 1'b1);
    wb_write = 1'b1;
    wb_addr = 5'd5;
    wb_data = 32'hAA;
    step();
    wb_write = 1'b0;
    check("bypass_rs_data", rs_data, 32'hAA);
    check("bypass_imm", imm_ext, 32'hFFFF_FFFF);
    check("bypass_ctrl", {22'd0, ctrl}, 32'h011);

    // Writes to r0 are ignored, even on the bypass path
    drive(enc_r(0, 0, 1, 6'h20), 32'h700, 1'b1);
    wb_write = 1'b1;
    wb_addr = 5'd0;
    wb_data = 32'hDEAD;
    step();
    wb_write = 1'b0;
    check("r0_rs_data", rs_data, 32'h0);
    drive(enc_i(6'h08, 5, 6, 16'hFFFF), 32'h600, 1'b1);
    step();
    check("pre_reset_ctrl", {22'd0, ctrl}, 32'h011);

    // Async reset mid-cycle, then r5 must read back as 0
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_ctrl", {22'd0, ctrl}, 32'h0);
    check("async_reset_rs_data", rs_data, 32'h0);
    #2;
    rst = 1'b0;
    step();
    drive(enc_i(6'h08, 5, 6, 16'hFFFF), 32'h800, 1'b1);
    step();
    check("post_reset_r5", rs_data, 32'h0);
    check("post_reset_ctrl", {22'd0, ctrl}, 32'h011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
